// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-side memory/MMIO subsystem: address map,
// timer CTRL bit positions, the decoded-region enum and the address decoder.
// No ports; imported by dmem_mmio and mmio_timer.
package dmem_mmio_pkg;

   // Address map (byte addresses; bits [1:0] are ignored everywhere)
   localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
   localparam logic [31:0] RAM_MASK    = 32'h0000_0FFF;
   localparam logic [31:0] MMIO_BASE   = 32'h1000_0000;
   localparam logic [31:0] LED_OFF     = 32'h0000_0000;
   localparam logic [31:0] SW_OFF      = 32'h0000_0004;
   localparam logic [31:0] COUNT_OFF   = 32'h0000_0008;
   localparam logic [31:0] COMPARE_OFF = 32'h0000_000C;
   localparam logic [31:0] CTRL_OFF    = 32'h0000_0010;

   // Timer CTRL register bit positions
   localparam int CTRL_EN   = 0;
   localparam int CTRL_PEND = 1;
   localparam int CTRL_AUTO = 2;
   localparam int CTRL_IEN  = 3;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_LED,
      REG_SW,
      REG_COUNT,
      REG_CMP,
      REG_CTRL,
      REG_NONE
   } region_t;

   // Word-granular decode: the two byte-offset bits are forced to zero first
   // so unaligned addresses alias onto their containing word.
   function automatic region_t decodeRegion(input logic [31:0] addr);
      logic [31:0] wordAddr;
      region_t     region;
      wordAddr = {addr[31:2], 2'b00};
      if ((wordAddr & ~RAM_MASK) == RAM_BASE)         region = REG_RAM;
      else if (wordAddr == (MMIO_BASE + LED_OFF))     region = REG_LED;
      else if (wordAddr == (MMIO_BASE + SW_OFF))      region = REG_SW;
      else if (wordAddr == (MMIO_BASE + COUNT_OFF))   region = REG_COUNT;
      else if (wordAddr == (MMIO_BASE + COMPARE_OFF)) region = REG_CMP;
      else if (wordAddr == (MMIO_BASE + CTRL_OFF))    region = REG_CTRL;
      else                                            region = REG_NONE;
      return region;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Compare/match timer: COUNT, COMPARE and CTRL registers, match detection, irq.
// Ports: clk/rst; wrCount/wrCompare/wrCtrl strobes with shared wrData;
//        count/compare/ctrl read views; irq = pending & ien, registered.
module mmio_timer
   import dmem_mmio_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wrCount,
   input  logic        wrCompare,
   input  logic        wrCtrl,
   input  logic [31:0] wrData,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic [31:0] ctrl,
   output logic        irq
);

   logic en;
   logic pend;
   logic autoReload;
   logic ien;
   logic match;
   logic pendNext;
   logic ienNext;

   // A disabled timer never evaluates a match.
   assign match = en && (count == compare);

   // Hardware set beats a same-cycle W1C; writing 0 to the pending bit is a no-op.
   always_comb begin
      pendNext = pend;
      if (match)
         pendNext = 1'b1;
      else if (wrCtrl && wrData[CTRL_PEND])
         pendNext = 1'b0;
   end

   assign ienNext = wrCtrl ? wrData[CTRL_IEN] : ien;

   always_comb begin
      ctrl            = '0;
      ctrl[CTRL_EN]   = en;
      ctrl[CTRL_PEND] = pend;
      ctrl[CTRL_AUTO] = autoReload;
      ctrl[CTRL_IEN]  = ien;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         compare    <= '1;
         en         <= 1'b0;
         pend       <= 1'b0;
         autoReload <= 1'b0;
         ien        <= 1'b0;
         irq        <= 1'b0;
      end else begin
         // A software load of COUNT takes priority over increment/reload.
         if (wrCount)
            count <= wrData;
         else if (en)
            count <= (match && autoReload) ? 32'h0 : count + 32'h1;

         if (wrCompare)
            compare <= wrData;

         if (wrCtrl) begin
            en         <= wrData[CTRL_EN];
            autoReload <= wrData[CTRL_AUTO];
            ien        <= wrData[CTRL_IEN];
         end

         pend <= pendNext;
         // irq is computed from next-state values so it is a flop output that
         // always equals pend & ien.
         irq  <= pendNext && ienNext;
      end
   end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory + MMIO block behind the core's memory stage: word RAM, LED
// register, 2-flop switch synchronizer, timer; reads are combinational.
// Ports: clk/rst; i_MemWriteM/i_ALUResultM/i_WriteDataM in, o_ReadDataM out;
//        i_sw (async), o_led (registered), o_timer_irq (registered).
module dmem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int DMEM_WORDS = 1024,
   parameter int SW_WIDTH   = 16,
   parameter int LED_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_MemWriteM,
   input  logic [31:0]          i_ALUResultM,
   input  logic [31:0]          i_WriteDataM,
   output logic [31:0]          o_ReadDataM,
   input  logic [SW_WIDTH-1:0]  i_sw,
   output logic [LED_WIDTH-1:0] o_led,
   output logic                 o_timer_irq
);

   localparam int IDX_W = $clog2(DMEM_WORDS);

   region_t             region;
   logic [IDX_W-1:0]    ramIdx;
   logic [31:0]         ram [DMEM_WORDS];
   logic [SW_WIDTH-1:0] swMeta;
   logic [SW_WIDTH-1:0] swSync;
   logic [31:0]         timerCount;
   logic [31:0]         timerCompare;
   logic [31:0]         timerCtrl;

   assign region = decodeRegion(i_ALUResultM);
   // Taking only the low index bits gives the wrap when the RAM is smaller
   // than the 4 KiB window.
   assign ramIdx = i_ALUResultM[IDX_W+1:2];

   // RAM is not reset; a store coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst && i_MemWriteM && (region == REG_RAM))
         ram[ramIdx] <= i_WriteDataM;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         o_led <= '0;
      else if (i_MemWriteM && (region == REG_LED))
         o_led <= i_WriteDataM[LED_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         swMeta <= '0;
         swSync <= '0;
      end else begin
         swMeta <= i_sw;
         swSync <= swMeta;
      end
   end

   mmio_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .wrCount   (i_MemWriteM && (region == REG_COUNT)),
      .wrCompare (i_MemWriteM && (region == REG_CMP)),
      .wrCtrl    (i_MemWriteM && (region == REG_CTRL)),
      .wrData    (i_WriteDataM),
      .count     (timerCount),
      .compare   (timerCompare),
      .ctrl      (timerCtrl),
      .irq       (o_timer_irq)
   );

   always_comb begin
      o_ReadDataM = 32'h0;
      case (region)
         REG_RAM:   o_ReadDataM = ram[ramIdx];
         REG_LED:   o_ReadDataM = 32'(o_led);
         REG_SW:    o_ReadDataM = 32'(swSync);
         REG_COUNT: o_ReadDataM = timerCount;
         REG_CMP:   o_ReadDataM = timerCompare;
         REG_CTRL:  o_ReadDataM = timerCtrl;
         default:   o_ReadDataM = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

   localparam logic [31:0] A_LED   = 32'h1000_0000;
   localparam logic [31:0] A_SW    = 32'h1000_0004;
   localparam logic [31:0] A_COUNT = 32'h1000_0008;
   localparam logic [31:0] A_CMP   = 32'h1000_000C;
   localparam logic [31:0] A_CTRL  = 32'h1000_0010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemWriteM = 1'b0;
   logic [31:0] ALUResultM = 32'h0;
   logic [31:0] WriteDataM = 32'h0;
   logic [31:0] ReadDataM;
   logic [15:0] sw = 16'h0;
   logic [15:0] led;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // Reference state for the randomized phase (timer disabled there)
   logic [31:0] mRam [1024];
   bit          mVal [1024];
   logic [15:0] mLed;
   logic [15:0] mSw;
   logic [31:0] mCount;
   logic [31:0] mCmp;

   dmem_mmio #(.DMEM_WORDS(1024), .SW_WIDTH(16), .LED_WIDTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_MemWriteM  (MemWriteM),
      .i_ALUResultM (ALUResultM),
      .i_WriteDataM (WriteDataM),
      .o_ReadDataM  (ReadDataM),
      .i_sw         (sw),
      .o_led        (led),
      .o_timer_irq  (irq)
   );

   always #5 clk = ~clk;

   task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
      MemWriteM = 1'b1; ALUResultM = a; WriteDataM = d;
      @(posedge clk); #1;
      MemWriteM = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] a, output logic [31:0] d);
      MemWriteM = 1'b0; ALUResultM = a;
      #1;
      d = ReadDataM;
   endtask

   task automatic resetDut();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      resetDut();
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led got %h exp 0000", led); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      busRead(A_COUNT, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 00000000", r); end
      busRead(A_CMP, r);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got %h exp ffffffff", r); end
      busRead(A_CTRL, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 00000000", r); end
      busRead(A_SW, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_sw got %h exp 00000000", r); end
   endtask

   task automatic test_ram();
      logic [31:0] r;
      busWrite(32'h104, 32'h1111_2222);
      busWrite(32'h100, 32'hDEAD_BEEF);
      busRead(32'h100, r);
      checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_100 got %h exp deadbeef", r); end
      busRead(32'h104, r);
      checks++; if (r !== 32'h1111_2222) begin errors++; $display("FAIL ram_104 got %h exp 11112222", r); end
      busRead(32'h102, r);
      checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_102 got %h exp deadbeef", r); end
   endtask

   task automatic test_led();
      logic [31:0] r;
      MemWriteM = 1'b1; ALUResultM = A_LED; WriteDataM = 32'h1234_ABCD;
      #1;
      checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL led_same_cycle got %h exp 00000000", ReadDataM); end
      @(posedge clk); #1;
      MemWriteM = 1'b0;
      checks++; if (led !== 16'hABCD) begin errors++; $display("FAIL led_out got %h exp abcd", led); end
      busRead(A_LED, r);
      checks++; if (r !== 32'h0000_ABCD) begin errors++; $display("FAIL led_read got %h exp 0000abcd", r); end
   endtask

   task automatic test_sw();
      logic [31:0] r;
      sw = 16'h00A5;
      busRead(A_SW, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL sw_edge0 got %h exp 00000000", r); end
      @(posedge clk); #1;
      busRead(A_SW, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL sw_edge1 got %h exp 00000000", r); end
      for (int i = 2; i < 5; i++) begin
         @(posedge clk); #1;
         busRead(A_SW, r);
         checks++; if (r !== 32'h0000_00A5) begin errors++; $display("FAIL sw_edge%0d got %h exp 000000a5", i, r); end
      end
   endtask

   task automatic test_timer_autoreload();
      logic [31:0] r;
      logic [31:0] exp;
      resetDut();
      busWrite(A_CMP, 32'd5);
      busWrite(A_CTRL, 32'hD);
      for (int i = 0; i <= 6; i++) begin
         exp = (i <= 5) ? i : 0;
         busRead(A_COUNT, r);
         checks++; if (r !== exp) begin errors++; $display("FAIL ar_count_%0d got %h exp %h", i, r, exp); end
         checks++; if (irq !== (i == 6)) begin errors++; $display("FAIL ar_irq_%0d got %b exp %b", i, irq, (i == 6)); end
         if (i < 6) begin @(posedge clk); #1; end
      end
      // W1C in a non-matching cycle (COUNT = 0)
      busWrite(A_CTRL, 32'hF);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_w1c_irq got %b exp 0", irq); end
      busRead(A_CTRL, r);
      checks++; if (r !== 32'hD) begin errors++; $display("FAIL ar_w1c_ctrl got %h exp 0000000d", r); end
      // COUNT is 1 now; advance to 5 and W1C during the matching cycle
      repeat (4) @(posedge clk); #1;
      busRead(A_COUNT, r);
      checks++; if (r !== 32'd5) begin errors++; $display("FAIL ar_pre_match got %h exp 00000005", r); end
      busWrite(A_CTRL, 32'hF);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ar_setwins_irq got %b exp 1", irq); end
      busRead(A_CTRL, r);
      checks++; if (r !== 32'hF) begin errors++; $display("FAIL ar_setwins_ctrl got %h exp 0000000f", r); end
   endtask

   task automatic test_timer_freerun();
      logic [31:0] r;
      resetDut();
      busWrite(A_COUNT, 32'hFFFF_FFFE);
      busWrite(A_CTRL, 32'h1);
      busRead(A_COUNT, r);
      checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL fr_count0 got %h exp fffffffe", r); end
      @(posedge clk); #1;
      busRead(A_COUNT, r);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fr_count1 got %h exp ffffffff", r); end
      @(posedge clk); #1;
      busRead(A_COUNT, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL fr_count2 got %h exp 00000000", r); end
      busRead(A_CTRL, r);
      checks++; if (r !== 32'h3) begin errors++; $display("FAIL fr_ctrl got %h exp 00000003", r); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fr_irq got %b exp 0", irq); end
      @(posedge clk); #1;
      busRead(A_COUNT, r);
      checks++; if (r !== 32'h1) begin errors++; $display("FAIL fr_count3 got %h exp 00000001", r); end
   endtask

   task automatic test_unmapped();
      logic [31:0] r;
      logic [31:0] ledBefore;
      busRead(32'h100, ledBefore);
      busWrite(32'h2000_0000, 32'hCAFE_F00D);
      busRead(32'h2000_0000, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 00000000", r); end
      busRead(32'h100, r);
      checks++; if (r !== ledBefore) begin errors++; $display("FAIL unmapped_side_effect got %h exp %h", r, ledBefore); end
   endtask

   task automatic test_async_reset();
      logic [31:0] r;
      resetDut();
      busWrite(32'h200, 32'h600D_F00D);
      busWrite(A_LED, 32'h0000_0055);
      busWrite(A_CMP, 32'd2);
      busWrite(A_CTRL, 32'h9);
      repeat (3) @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ares_pre_irq got %b exp 1", irq); end
      #2 rst = 1'b1;
      #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ares_irq got %b exp 0", irq); end
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL ares_led got %h exp 0000", led); end
      busRead(A_COUNT, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL ares_count got %h exp 00000000", r); end
      // A store presented while reset is held must be dropped
      @(negedge clk);
      MemWriteM = 1'b1; ALUResultM = 32'h200; WriteDataM = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      MemWriteM = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      busRead(32'h200, r);
      checks++; if (r === 32'hBAD0_BAD0) begin errors++; $display("FAIL ares_store_lost got %h exp not bad0bad0", r); end
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] a, output bit known);
      logic [31:0] w;
      int idx;
      w = a & 32'hFFFF_FFFC;
      known = 1'b1;
      if (w < 32'h1000) begin
         idx = int'(w[11:0] / 4) % 1024;
         known = mVal[idx];
         return mRam[idx];
      end
      if (w == A_LED)   return {16'h0, mLed};
      if (w == A_SW)    return {16'h0, mSw};
      if (w == A_COUNT) return mCount;
      if (w == A_CMP)   return mCmp;
      if (w == A_CTRL)  return 32'h0;
      return 32'h0;
   endfunction

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
      bit          we;
      bit          known;
      int          kind;
      logic [31:0] unm [5];
      unm[0] = 32'h2000_0000; unm[1] = 32'h1000_0014; unm[2] = 32'h1000_1000;
      unm[3] = 32'h0000_1000; unm[4] = 32'hFFFF_FFFC;
      resetDut();
      sw = 16'h3C5A;
      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < 1024; i++) mVal[i] = 1'b0;
      mLed = 16'h0; mSw = 16'h3C5A; mCount = 32'h0; mCmp = 32'hFFFF_FFFF;
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 7);
         case (kind)
            0, 1, 2: a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
            3:       a = A_LED + $urandom_range(0, 3);
            4:       a = A_SW;
            5:       a = A_CMP;
            6:       a = A_COUNT;
            default: a = unm[$urandom_range(0, 4)];
         endcase
         we = ($urandom_range(0, 1) == 1);
         d  = $urandom;
         MemWriteM = we; ALUResultM = a; WriteDataM = d;
         #1;
         exp = modelRead(a, known);
         if (known) begin
            checks++;
            if (ReadDataM !== exp) begin errors++; $display("FAIL rand_read_%0d addr %h got %h exp %h", n, a, ReadDataM, exp); end
         end
         @(posedge clk); #1;
         MemWriteM = 1'b0;
         if (we) begin
            if ((a & 32'hFFFF_FFFC) < 32'h1000) begin
               mRam[int'(a[11:2])] = d;
               mVal[int'(a[11:2])] = 1'b1;
            end else if ((a & 32'hFFFF_FFFC) == A_LED) mLed = d[15:0];
            else if (a == A_CMP)   mCmp = d;
            else if (a == A_COUNT) mCount = d;
         end
         checks++;
         if (led !== mLed) begin errors++; $display("FAIL rand_led_%0d got %h exp %h", n, led, mLed); end
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_led();
      test_sw();
      test_unmapped();
      test_timer_autoreload();
      test_timer_freerun();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory subsystem directly downstream of the pipelined core's memory stage.
- Consumes MemWriteM, ALUResultM and WriteDataM from the core and returns ReadDataM in the same cycle.
- Decodes the address into a word-addressed data RAM and a small MMIO register file: LED output, synchronized switch input, and a compare/match timer with an interrupt line.

Parameters:
- DMEM_WORDS, 1024: data RAM depth in 32-bit words (power of two, at most 1024).
- SW_WIDTH, 16: switch input width.
- LED_WIDTH, 16: LED output width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_MemWriteM  input  1  store strobe from the memory stage.
- i_ALUResultM  input  32  byte address.
- i_WriteDataM  input  32  store data.
- o_ReadDataM  output  32  load data, combinational from the address.
- i_sw  input  SW_WIDTH  asynchronous board switches.
- o_led  output  LED_WIDTH  LED register, registered output.
- o_timer_irq  output  1  timer interrupt = pending AND ien, driven from registers only.

Behaviour:
- One clock domain. Reset is asynchronous and active-high on rst.
- Reset values:
  - o_led = 0; switch synchronizer flops = 0.
  - timer COUNT = 0, COMPARE = 0xFFFF_FFFF, CTRL = 0; o_timer_irq = 0.
  - RAM contents are not reset and are undefined until written.
- Word access only. addr[1:0] is ignored on all accesses; there are no byte enables.
- Address map:
  - 0x0000_0000 to 0x0000_0FFF: RAM, index = addr[11:2] modulo DMEM_WORDS (wraps when the RAM is smaller than the window).
  - 0x1000_0000 LED: RW. Write latches WriteData[LED_WIDTH-1:0]; read returns the value zero-extended.
  - 0x1000_0004 SW: RO. Read returns the 2-flop-synchronized i_sw, zero-extended.
  - 0x1000_0008 COUNT: RW. Write loads the value.
  - 0x1000_000C COMPARE: RW.
  - 0x1000_0010 CTRL: bit0 en, bit1 pending (write-1-to-clear), bit2 autoreload, bit3 ien. Other bits read 0.
  - Any other address: reads return 0, writes are ignored, no error.
- Reads:
  - Purely combinational: o_ReadDataM reflects the current register or RAM contents for i_ALUResultM in the same cycle.
  - Reads have no side effects.
- Writes:
  - Take effect on the rising edge where i_MemWriteM = 1.
  - A read of the same location in the same cycle returns the old value.
- Timer, per clock:
  - If en = 1: when COUNT == COMPARE, set pending; next COUNT = 0 if autoreload = 1, else COUNT + 1.
  - If en = 1 and no match: COUNT + 1, wrapping at 2^32.
  - If en = 0: COUNT holds and no match is evaluated.
- Simultaneous events:
  - A software write to COUNT overrides the increment or reload in that cycle.
  - A hardware pending-set and a W1C in the same cycle: set wins, pending stays 1.
  - A CTRL write updates en, autoreload and ien. The pending bit changes only via set or W1C; writing 0 to bit1 leaves it unchanged.
- Switch synchronizer: i_sw appears in SW reads after exactly 2 rising edges.
- Reset asserted mid-operation:
  - All registers clear immediately, without waiting for a clock edge.
  - o_timer_irq drops in the same cycle.
  - A store in flight is lost.
  - RAM contents are retained but unspecified.

Decomposition:
- Package dmem_mmio_pkg holds:
  - Address constants: RAM_BASE, RAM_MASK, MMIO_BASE, LED_OFF, SW_OFF, COUNT_OFF, COMPARE_OFF, CTRL_OFF.
  - CTRL bit indices: CTRL_EN, CTRL_PEND, CTRL_AUTO, CTRL_IEN.
  - A typedef enum for the decoded region (REG_RAM, REG_LED, REG_SW, REG_COUNT, REG_CMP, REG_CTRL, REG_NONE).
- One sub-module, mmio_timer, owns COUNT, COMPARE and CTRL, the match logic and the irq output.
- RAM, LED register, synchronizer and read mux stay in the top module.

Test Plan:
- RAM: store 0xDEADBEEF to 0x100, then load 0x100 -> 0xDEADBEEF. Load 0x104 -> its prior value. Load 0x102 -> 0xDEADBEEF (low address bits ignored).
- LED: store 0x1234ABCD to 0x1000_0000 -> o_led = 0xABCD after that edge. Readback -> 0x0000ABCD. Same-cycle read during the store -> old value.
- SW: drive i_sw = 0x00A5 -> reads of 0x1000_0004 return the old value after 1 edge and 0x000000A5 from the 2nd edge on.
- Timer autoreload: write COMPARE = 5, then CTRL = 0xD (en, autoreload, ien) -> COUNT goes 0..5, then 0. pending and o_timer_irq rise on the edge leaving COUNT = 5. Writing CTRL = 0xF clears pending and irq unless a match occurs in that same cycle.
- Timer free-run: en only, COMPARE = 0xFFFF_FFFF, preload COUNT = 0xFFFF_FFFE -> COUNT goes FFFF_FFFE, FFFF_FFFF, 0. pending = 1 and o_timer_irq stays 0 (ien = 0).
- Unmapped and reset: store to 0x2000_0000 has no visible effect and its load returns 0. Assert rst asynchronously mid-count -> COUNT, o_led and o_timer_irq are 0 before the next clock edge.
